alu_scheduler: RTL and testbench

- Shares one 32-bit ALU between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshake on each request port.
- One operation in flight at a time; the result is registered and returned with the requester ID.
- Sits between decode/issue agents and the shared ALU datapath, and sequences each operation through accept, execute and respond.

---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/alu_scheduler_alu_core.sv | 52 +++++
 rtl/alu_scheduler.sv | 157 +++++++++++++++
 tb/tb_alu_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU scheduler: ALU control codes and FSM state encodings.
package alu_sched_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu_scheduler_alu_core.sv
// Combinational 32-bit ALU used by alu_scheduler.
// Signed-overflow detection on ADD/SUB is present only when ALU_SCHED_OVF_EN is defined.
module alu_core
  import alu_sched_pkg::*;
(
  input  logic [3:0]  control,
  input  logic [31:0] operand0,
  input  logic [31:0] operand1,
  output logic [31:0] result,
  output logic        zero,
  output logic        err,
  output logic        ovf
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = operand0 + operand1;
  assign diff = operand0 - operand1;

  always_comb begin
    result = 32'h0;
    err    = 1'b0;
    case (control)
      ALU_AND: result = operand0 & operand1;
      ALU_OR:  result = operand0 | operand1;
      ALU_ADD: result = sum;
      ALU_XOR: result = operand0 ^ operand1;
      ALU_SUB: result = diff;
      ALU_SLT: result = {31'h0, $signed(operand0) < $signed(operand1)};
      ALU_NOR: result = ~(operand0 | operand1);
      default: err = 1'b1;
    endcase
  end

  assign zero = (result == 32'h0);

`ifdef ALU_SCHED_OVF_EN
  // Overflow when the operand signs permit it and the result sign flips away from operand0.
  always_comb begin
    ovf = 1'b0;
    case (control)
      ALU_ADD: ovf = (operand0[31] == operand1[31]) && (sum[31] != operand0[31]);
      ALU_SUB: ovf = (operand0[31] != operand1[31]) && (diff[31] != operand0[31]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters; one op in flight.
// Optional signed-overflow flag enabled by defining ALU_SCHED_OVF_EN.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_control,
  input  logic [32*NUM_REQ-1:0]   req_operand0,
  input  logic [32*NUM_REQ-1:0]   req_operand1,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic                    resp_ovf
);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [31:0]     op0_q, op0_d;
  logic [31:0]     op1_q, op1_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic            resp_zero_q, resp_zero_d;
  logic            resp_err_q, resp_err_d;
  logic            resp_ovf_q, resp_ovf_d;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [31:0]     alu_result;
  logic            alu_zero;
  logic            alu_err;
  logic            alu_ovf;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  alu_core u_alu_core (
    .control  (ctrl_q),
    .operand0 (op0_q),
    .operand1 (op1_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .err      (alu_err),
    .ovf      (alu_ovf)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ctrl_d        = ctrl_q;
    op0_d         = op0_q;
    op1_d         = op1_q;
    id_d          = id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
    resp_ovf_d    = resp_ovf_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ctrl_d   = req_control[4*winner +: 4];
          op0_d    = req_operand0[32*winner +: 32];
          op1_d    = req_operand1[32*winner +: 32];
          id_d     = winner;
          rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_result_d = alu_result;
        resp_zero_d   = alu_zero;
        resp_err_d    = alu_err;
        resp_ovf_d    = alu_ovf;
        state_d       = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      ctrl_q        <= '0;
      op0_q         <= '0;
      op1_q         <= '0;
      id_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_ovf_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ctrl_q        <= ctrl_d;
      op0_q         <= op0_d;
      op1_q         <= op1_d;
      id_q          <= id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
      resp_ovf_q    <= resp_ovf_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign resp_ovf    = resp_ovf_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler; overflow expectations follow ALU_SCHED_OVF_EN.
module tb_alu_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   reqValid;
  logic [3:0]   reqReady;
  logic [15:0]  reqControl;
  logic [127:0] reqOperand0;
  logic [127:0] reqOperand1;
  logic         respValid;
  logic         respReady;
  logic [1:0]   respId;
  logic [31:0]  respResult;
  logic         respZero;
  logic         respErr;
  logic         respOvf;

  int checkCount = 0;
  int failCount  = 0;

`ifdef ALU_SCHED_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (reqValid),
    .req_ready    (reqReady),
    .req_control  (reqControl),
    .req_operand0 (reqOperand0),
    .req_operand1 (reqOperand1),
    .resp_valid   (respValid),
    .resp_ready   (respReady),
    .resp_id      (respId),
    .resp_result  (respResult),
    .resp_zero    (respZero),
    .resp_err     (respErr),
    .resp_ovf     (respOvf)
  );

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete op on a single requester: accept, exec, respond with resp_ready high.
  task automatic applyStimulus(input int reqIdx, input logic [3:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expResult, input logic expErr,
                               input logic expOvf);
    logic [31:0] oneHot;
    oneHot = 32'd1 << reqIdx;
    @(negedge clk);
    reqValid = '0;
    reqValid[reqIdx] = 1'b1;
    reqControl[4*reqIdx +: 4]    = ctrl;
    reqOperand0[32*reqIdx +: 32] = a;
    reqOperand1[32*reqIdx +: 32] = b;
    #1;
    checkOutput("grant", 32'(reqReady), oneHot);
    @(negedge clk);
    reqValid = '0;
    checkOutput("exec_valid", 32'(respValid), 32'd0);
    checkOutput("exec_ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("resp_valid", 32'(respValid), 32'd1);
    checkOutput("resp_id", 32'(respId), 32'(reqIdx));
    checkOutput("resp_result", respResult, expResult);
    checkOutput("resp_zero", 32'(respZero), 32'(expResult == 32'h0));
    checkOutput("resp_err", 32'(respErr), 32'(expErr));
    checkOutput("resp_ovf", 32'(respOvf), 32'(expOvf));
    @(negedge clk);
    checkOutput("resp_clear", 32'(respValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    reset       = 1'b1;
    reqValid    = 4'hF;
    respReady   = 1'b1;
    reqControl  = '0;
    reqOperand0 = '0;
    reqOperand1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
    checkOutput("rst_resp_id", 32'(respId), 32'd0);
    checkOutput("rst_resp_result", respResult, 32'd0);
    checkOutput("rst_resp_flags", {29'd0, respZero, respErr, respOvf}, 32'd0);
    reqValid = '0;
    reset    = 1'b0;

    $display("[TB] single ops on requesters 0 and 1");
    applyStimulus(0, 4'b0010, 32'hffffff68, 32'hffffff34, 32'hfffffe9c, 1'b0, 1'b0);
    applyStimulus(0, 4'b0110, 32'hffffff68, 32'hffffff34, 32'h00000034, 1'b0, 1'b0);
    applyStimulus(1, 4'b0000, 32'hffffff68, 32'hffffff34, 32'hffffff20, 1'b0, 1'b0);
    applyStimulus(1, 4'b0001, 32'hffffff68, 32'hffffff34, 32'hffffff7c, 1'b0, 1'b0);
    applyStimulus(1, 4'b0011, 32'hffffff68, 32'hffffff34, 32'h0000005c, 1'b0, 1'b0);
    applyStimulus(1, 4'b1100, 32'h00000000, 32'hffffff34, 32'h000000cb, 1'b0, 1'b0);
    applyStimulus(1, 4'b0111, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    applyStimulus(1, 4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    applyStimulus(2, 4'b0011, 32'hcafef00d, 32'hcafef00d, 32'h00000000, 1'b0, 1'b0);
    applyStimulus(3, 4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, OVF_EN);
    applyStimulus(3, 4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, OVF_EN);

    $display("[TB] round robin with all requesters valid");
    doReset();
    for (int i = 0; i < 4; i++) begin
      reqControl[4*i +: 4]    = 4'b0010;
      reqOperand0[32*i +: 32] = 32'(i);
      reqOperand1[32*i +: 32] = 32'h100;
    end
    reqValid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("rr_grant", 32'(reqReady), 32'd1 << (k % 4));
      checkOutput("rr_onehot", $countones(reqReady), 32'd1);
      @(negedge clk);
      checkOutput("rr_exec_ready", 32'(reqReady), 32'd0);
      @(negedge clk);
      checkOutput("rr_resp_ready", 32'(reqReady), 32'd0);
      checkOutput("rr_resp_id", 32'(respId), 32'(k % 4));
      checkOutput("rr_resp_result", respResult, 32'h100 + 32'(k % 4));
      @(negedge clk);
    end
    reqValid = '0;

    $display("[TB] backpressure on the response");
    doReset();
    respReady = 1'b0;
    reqValid  = 4'b0100;
    reqControl[11:8]    = 4'b0011;
    reqOperand0[95:64]  = 32'h12345678;
    reqOperand1[95:64]  = 32'h0f0f0f0f;
    #1;
    checkOutput("bp_grant", 32'(reqReady), 32'h4);
    @(negedge clk);
    reqValid = 4'b0001;
    checkOutput("bp_exec_ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("bp_result", respResult, 32'h1d3b5977);
    held = respResult;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(respValid), 32'd1);
      checkOutput("bp_hold_result", respResult, held);
      checkOutput("bp_hold_id", 32'(respId), 32'd2);
      checkOutput("bp_hold_ready", 32'(reqReady), 32'd0);
    end
    reqValid  = '0;
    respReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", 32'(respValid), 32'd0);

    $display("[TB] reset during execute");
    applyStimulus(1, 4'b0010, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
    @(negedge clk);
    reqValid = 4'b0010;
    #1;
    checkOutput("mid_grant", 32'(reqReady), 32'h2);
    @(negedge clk);
    reqValid = '0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_resp_valid", 32'(respValid), 32'd0);
    @(negedge clk);
    checkOutput("mid_no_resp", 32'(respValid), 32'd0);
    reqValid = 4'b1001;
    #1;
    checkOutput("mid_next_grant", 32'(reqReady), 32'h1);
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    checkOutput("mid_next_id", 32'(respId), 32'd0);
    checkOutput("mid_next_valid", 32'(respValid), 32'd1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
